// File: rtl/sensor_access_scheduler_if.sv
// Handshake bundle between the request decoder, the DHT11 front end and the UART response path.
interface sensor_access_scheduler_if;
  logic        req_valid;
  logic [7:0]  req_code;
  logic        req_ready;
  logic        sensor_start;
  logic        sensor_done;
  logic        sensor_error;
  logic [39:0] sensor_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_code;
  logic [7:0]  resp_value;
  logic        busy;

  modport master (
    output req_valid, req_code, sensor_done, sensor_error, sensor_data, resp_ready,
    input  req_ready, sensor_start, resp_valid, resp_code, resp_value, busy
  );

  modport slave (
    input  req_valid, req_code, sensor_done, sensor_error, sensor_data, resp_ready,
    output req_ready, sensor_start, resp_valid, resp_code, resp_value, busy
  );
endinterface

// File: rtl/sensor_access_scheduler.sv
// Arbitrates DHT11 reads between client one-shots and continuous monitoring,
// enforcing the inter-read gap and access timeout, and emits one response per access/command.
module sensor_access_scheduler #(
  parameter int unsigned MIN_GAP_CYCLES = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input logic                      clock,
  input logic                      reset_n,
  sensor_access_scheduler_if.slave bus
);

  localparam int unsigned GAP_W = $clog2(MIN_GAP_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_HOLDOFF, S_START, S_WAIT, S_RESPOND} state_t;
  typedef enum logic [1:0] {MODE_OFF = 2'b00, MODE_TEMP = 2'b01, MODE_HUM = 2'b10} mode_t;

  state_t           state, state_d;
  mode_t            mode, mode_d;
  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             run;
  logic             tag_hum, tag_hum_d, tag_cont, tag_cont_d;
  logic [7:0]       code_q, value_q, code_d, value_d;
  logic             cap, wait_exit;

  logic [7:0] hum_int, hum_dec, temp_int, temp_dec, csum, sum_b;
  logic       csum_ok;

  assign hum_int  = bus.sensor_data[39:32];
  assign hum_dec  = bus.sensor_data[31:24];
  assign temp_int = bus.sensor_data[23:16];
  assign temp_dec = bus.sensor_data[15:8];
  assign csum     = bus.sensor_data[7:0];
  assign sum_b    = hum_int + hum_dec + temp_int + temp_dec;
  assign csum_ok  = (sum_b == csum);

  // run holds req_ready low until the first edge after reset release
  assign bus.req_ready    = (state == S_IDLE) && run;
  assign bus.sensor_start = (state == S_START);
  assign bus.resp_valid   = (state == S_RESPOND);
  assign bus.resp_code    = code_q;
  assign bus.resp_value   = value_q;
  assign bus.busy         = (state != S_IDLE);

  always_comb begin
    state_d    = state;
    mode_d     = mode;
    tag_hum_d  = tag_hum;
    tag_cont_d = tag_cont;
    cap        = 1'b0;
    wait_exit  = 1'b0;
    code_d     = '0;
    value_d    = '0;
    case (state)
      S_IDLE: begin
        if (run && bus.req_valid) begin
          case (bus.req_code)
            8'h01, 8'h02: begin
              state_d    = S_HOLDOFF;
              tag_cont_d = 1'b0;
              tag_hum_d  = (bus.req_code == 8'h02);
            end
            8'h03: begin mode_d = MODE_TEMP; cap = 1'b1; code_d = 8'h0A; state_d = S_RESPOND; end
            8'h04: begin mode_d = MODE_HUM;  cap = 1'b1; code_d = 8'h0B; state_d = S_RESPOND; end
            8'h05: begin mode_d = MODE_OFF;  cap = 1'b1; code_d = 8'h0C; state_d = S_RESPOND; end
            default: begin
              cap     = 1'b1;
              code_d  = 8'hEF;
              value_d = bus.req_code;
              state_d = S_RESPOND;
            end
          endcase
        end else if (run && mode != MODE_OFF && gap_cnt == '0) begin
          state_d    = S_START;
          tag_cont_d = 1'b1;
          tag_hum_d  = (mode == MODE_HUM);
        end
      end
      S_HOLDOFF: if (gap_cnt == '0) state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT: begin
        wait_exit = bus.sensor_done || bus.sensor_error || (to_cnt == TO_LAST);
        if (wait_exit) begin
          cap     = 1'b1;
          state_d = S_RESPOND;
          code_d  = 8'h1F;
          if (bus.sensor_done) begin
            if (!csum_ok)     value_d = 8'h02;
            else if (tag_hum) begin code_d = tag_cont ? 8'h0B : 8'h08; value_d = hum_int;  end
            else              begin code_d = tag_cont ? 8'h0A : 8'h09; value_d = temp_int; end
          end else if (bus.sensor_error) begin
            value_d = 8'h01;
          end
        end
      end
      S_RESPOND: if (bus.resp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      mode     <= MODE_OFF;
      run      <= 1'b0;
      tag_hum  <= 1'b0;
      tag_cont <= 1'b0;
      code_q   <= '0;
      value_q  <= '0;
      gap_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_d;
      mode     <= mode_d;
      run      <= 1'b1;
      tag_hum  <= tag_hum_d;
      tag_cont <= tag_cont_d;
      if (cap) begin
        code_q  <= code_d;
        value_q <= value_d;
      end
      if (wait_exit)           gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GAP_W'(1);
      if (state == S_START)     to_cnt <= '0;
      else if (state == S_WAIT) to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_sensor_access_scheduler.sv
// Directed and randomized checks of sensor_access_scheduler against a cycle-level behavioural model.
module tb_sensor_access_scheduler;
  localparam int unsigned MIN_GAP = 20;
  localparam int unsigned TMO     = 50;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   last_exit = -1000;
  int   last_r    = 0;

  sensor_access_scheduler_if bus ();

  sensor_access_scheduler #(.MIN_GAP_CYCLES(MIN_GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ge(input string tag, input int obs, input int min);
    checks++;
    assert (obs >= min) else begin
      errors++;
      $error("FAIL %s: observed %0d expected at least %0d", tag, obs, min);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},    bus.req_ready,    1'b0);
    chk({tag, "_sensor_start"}, bus.sensor_start, 1'b0);
    chk({tag, "_resp_valid"},   bus.resp_valid,   1'b0);
    chk({tag, "_resp_code"},    bus.resp_code,    8'h00);
    chk({tag, "_resp_value"},   bus.resp_value,   8'h00);
    chk({tag, "_busy"},         bus.busy,         1'b0);
  endtask

  // kind: 0 client temp, 1 client hum, 2 continuous temp, 3 continuous hum
  // outcome: 0 done, 1 error, 2 done+error together, 3 no reply
  function automatic logic [15:0] model(input int kind, input int outcome, input logic [39:0] d);
    int h, hd, t, td, c;
    h = int'(d[39:32]); hd = int'(d[31:24]); t = int'(d[23:16]); td = int'(d[15:8]); c = int'(d[7:0]);
    if (outcome == 3) return 16'h1F00;
    if (outcome == 1) return 16'h1F01;
    if (((h + hd + t + td) % 256) != c) return 16'h1F02;
    case (kind)
      0:       return {8'h09, d[23:16]};
      1:       return {8'h08, d[39:32]};
      2:       return {8'h0A, d[23:16]};
      default: return {8'h0B, d[39:32]};
    endcase
  endfunction

  function automatic logic [39:0] make_data(input bit good);
    logic [7:0] h, hd, t, td, c;
    h = 8'($urandom); hd = 8'($urandom); t = 8'($urandom); td = 8'($urandom);
    c = h + hd + t + td;
    if (!good) c = c + 8'($urandom_range(1, 255));
    return {h, hd, t, td, c};
  endfunction

  task automatic send_cmd(input logic [7:0] code, output int t);
    t = -1;
    bus.req_valid = 1'b1;
    bus.req_code  = code;
    for (int i = 0; i < 300; i++) begin
      if (bus.req_ready) begin
        t = cyc;
        tick();
        break;
      end
      tick();
    end
    bus.req_valid = 1'b0;
    bus.req_code  = 8'h00;
    chk("cmd_accepted", t >= 0, 1'b1);
  endtask

  task automatic wait_start(output int s);
    s = -1;
    for (int i = 0; i < 600; i++) begin
      if (bus.sensor_start) begin
        s = cyc;
        break;
      end
      tick();
    end
    chk("start_seen", s >= 0, 1'b1);
    tick();
    chk("start_one_cycle", bus.sensor_start, 1'b0);
  endtask

  task automatic reply(input int s, input int dly, input int outcome, input logic [39:0] data,
                       output int x);
    bus.sensor_data = data;
    if (outcome == 3) begin
      x = s + int'(TMO);
    end else begin
      while (cyc < s + dly) tick();
      bus.sensor_done  = (outcome != 1);
      bus.sensor_error = (outcome != 0);
      x = cyc;
      tick();
      bus.sensor_done  = 1'b0;
      bus.sensor_error = 1'b0;
    end
  endtask

  task automatic get_resp(input logic [7:0] ec, input logic [7:0] ev, input int exp_cyc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus.resp_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("resp_seen", found, 1'b1);
    if (exp_cyc >= 0) chk("resp_cycle", cyc, exp_cyc);
    chk("resp_code", bus.resp_code, ec);
    chk("resp_value", bus.resp_value, ev);
    chk("resp_busy", bus.busy, 1'b1);
    bus.resp_ready = 1'b1;
    last_r = cyc;
    tick();
    bus.resp_ready = 1'b0;
    chk("ready_after_resp", bus.req_ready, 1'b1);
  endtask

  // Start cycle follows from acceptance (T+2) or the gap expiring (exit+MIN+1 idle, START next).
  task automatic finish_read(input int t, input int kind, input int outcome, input int dly,
                             input logic [39:0] data);
    int s, x, es;
    logic [15:0] e;
    wait_start(s);
    es = (t + 2 > last_exit + int'(MIN_GAP) + 2) ? t + 2 : last_exit + int'(MIN_GAP) + 2;
    chk("start_cycle", s, es);
    chk_ge("start_gap", s - last_exit, int'(MIN_GAP));
    chk("busy_wait", bus.busy, 1'b1);
    chk("ready_wait", bus.req_ready, 1'b0);
    reply(s, dly, outcome, data, x);
    last_exit = x;
    e = model(kind, outcome, data);
    get_resp(e[15:8], e[7:0], x + 1);
  endtask

  task automatic monitor_quiet(input string tag, input int n);
    int starts, resps;
    starts = 0;
    resps  = 0;
    for (int i = 0; i < n; i++) begin
      starts += int'(bus.sensor_start);
      resps  += int'(bus.resp_valid);
      tick();
    end
    chk({tag, "_starts"}, starts, 0);
    chk({tag, "_resps"}, resps, 0);
  endtask

  initial begin
    int t, s, x;
    logic [39:0] d;
    bus.req_valid    = 1'b0;
    bus.req_code     = 8'h00;
    bus.sensor_done  = 1'b0;
    bus.sensor_error = 1'b0;
    bus.sensor_data  = '0;
    bus.resp_ready   = 1'b0;

    // reset and release
    repeat (3) tick();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    chk("ready_at_release", bus.req_ready, 1'b0);
    tick();
    chk("ready_after_release", bus.req_ready, 1'b1);

    // scenario 1: good temperature read
    send_cmd(8'h01, t);
    finish_read(t, 0, 0, 10, 40'h37_00_19_00_50);

    // scenario 2: checksum mismatch, then back-to-back humidity read
    send_cmd(8'h02, t);
    finish_read(t, 1, 0, 7, 40'h37_00_19_00_51);
    send_cmd(8'h02, t);
    finish_read(t, 1, 0, 4, 40'h37_00_19_00_50);

    // scenario 3: timeout, then simultaneous done+error
    send_cmd(8'h01, t);
    finish_read(t, 0, 3, 0, 40'h37_00_19_00_50);
    send_cmd(8'h01, t);
    finish_read(t, 0, 2, 5, 40'h37_00_19_00_50);

    // scenario 4: continuous temperature, client beats tick, then off
    send_cmd(8'h03, t);
    get_resp(8'h0A, 8'h00, t + 1);
    for (int k = 0; k < 2; k++) finish_read(last_r, 2, 0, $urandom_range(1, 12), make_data(1'b1));
    x = last_exit;
    while (cyc < x + int'(MIN_GAP) + 1) tick();
    send_cmd(8'h01, t);
    chk("client_beats_tick", t, x + int'(MIN_GAP) + 1);
    finish_read(t, 0, 0, 6, make_data(1'b1));
    send_cmd(8'h05, t);
    get_resp(8'h0C, 8'h00, t + 1);
    monitor_quiet("cont_off", 60);

    // scenario 5: unknown command with stalled response; stray done ignored
    send_cmd(8'h7E, t);
    chk("unk_cycle", cyc, t + 1);
    bus.sensor_data = make_data(1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", bus.resp_valid, 1'b1);
      chk("stall_code", bus.resp_code, 8'hEF);
      chk("stall_value", bus.resp_value, 8'h7E);
      chk("stall_ready", bus.req_ready, 1'b0);
      bus.sensor_done = (k == 2);
      tick();
      bus.sensor_done = 1'b0;
    end
    get_resp(8'hEF, 8'h7E, -1);

    // scenario 6: reset during a continuous read
    send_cmd(8'h03, t);
    get_resp(8'h0A, 8'h00, t + 1);
    wait_start(s);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (3) tick();
    chk_reset_vals("midrst_hold");
    reset_n = 1'b1;
    tick();
    monitor_quiet("post_rst", 60);
    chk("post_rst_ready", bus.req_ready, 1'b1);
    last_exit = -1000;

    // randomized client traffic
    for (int k = 0; k < 12; k++) begin
      int op;
      logic [7:0] code;
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        d = make_data(bit'($urandom_range(0, 1)));
        send_cmd(op == 0 ? 8'h01 : 8'h02, t);
        finish_read(t, op, $urandom_range(0, 3), $urandom_range(1, 15), d);
      end else if (op == 2) begin
        code = 8'($urandom_range(6, 255));
        send_cmd(code, t);
        get_resp(8'hEF, code, t + 1);
      end else begin
        send_cmd(8'h05, t);
        get_resp(8'h0C, 8'h00, t + 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
